// File: rtl/serial_addsub_if.sv
// serial_addsub_if: start/done handshake, operands and result/flag bus of the
// digit-serial adder/subtractor. The requester drives the master side; the
// arithmetic unit sits on the slave side.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cf;
  logic             of;
  logic             zf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cf, of, zf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cf, of, zf
  );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor that walks the operands LSB first,
// DIGIT bits per clock, through a DIGIT-wide ripple-carry slice. One operation
// takes N = WIDTH/DIGIT RUN cycles followed by a one-cycle DONE pulse.
// Optional feature: define SERIAL_ADDSUB_SAT_EN for signed saturation of s
// (cf/of still describe the unsaturated operation, zf follows the clamped s).
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             last;
  logic [CW-1:0]    cnt;

  // Operand shift registers; B is stored already inverted for subtraction.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;

  logic [DIGIT-1:0] sum_dig;
  logic             c_out;
  logic             c_msb_in;
  logic             ovf;
  logic [WIDTH-1:0] sum_word;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] s_next;

`ifdef SERIAL_ADDSUB_SAT_EN
  logic             a_sign;

  // Clamp to the signed extreme matching the sign of operand A on overflow.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] wrapped,
                                                input logic             overflow,
                                                input logic             sign);
    logic signed [WIDTH-1:0] max_pos;
    logic signed [WIDTH-1:0] min_neg;
    max_pos = {1'b0, {(WIDTH-1){1'b1}}};
    min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    if (!overflow) return wrapped;
    return sign ? min_neg : max_pos;
  endfunction
`endif

  assign last     = (cnt == CW'(N - 1));
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state: accept start only from IDLE/DONE, leave RUN after the last digit.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ripple-carry slice over the current digit; also exposes the carry into its top bit.
  always_comb begin
    logic c;
    c        = carry;
    sum_dig  = '0;
    c_msb_in = carry;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb_in   = c;
      sum_dig[i] = a_sr[i] ^ b_sr[i] ^ c;
      c          = (a_sr[i] & b_sr[i]) | (c & (a_sr[i] ^ b_sr[i]));
    end
    c_out = c;
  end

  // On the final digit the top bit of the slice is the word MSB, so c_msb_in
  // is the carry into the MSB and ovf is the signed overflow of the word.
  assign ovf      = c_msb_in ^ c_out;
  assign sum_word = WIDTH'(sum_dig);
  assign res_next = (res_sr >> DIGIT) | (sum_word << (WIDTH - DIGIT));

`ifdef SERIAL_ADDSUB_SAT_EN
  assign s_next = saturate(res_next, ovf, a_sign);
`else
  assign s_next = res_next;
`endif

  // Operand/result datapath: capture on accepted start, shift one digit per RUN cycle.
  always_ff @(posedge clk) begin
    if (load) begin
      a_sr   <= bus.a;
      b_sr   <= bus.sub ? ~bus.b : bus.b;
`ifdef SERIAL_ADDSUB_SAT_EN
      a_sign <= bus.a[WIDTH-1];
`endif
    end else if (step) begin
      a_sr   <= a_sr >> DIGIT;
      b_sr   <= b_sr >> DIGIT;
      res_sr <= res_next;
    end
  end

  // Digit counter and running carry; subtraction starts with the inverted borrow-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      carry <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      carry <= bus.sub ? ~bus.cin : bus.cin;
    end else if (step) begin
      cnt   <= cnt + CW'(1);
      carry <= c_out;
    end
  end

  // Result and flags change only when an operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.s  <= '0;
      bus.cf <= 1'b0;
      bus.of <= 1'b0;
      bus.zf <= 1'b0;
    end else if (step && last) begin
      bus.s  <= s_next;
      bus.cf <= c_out;
      bus.of <= ovf;
      bus.zf <= (s_next == '0);
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed bench for serial_addsub, WIDTH=8/DIGIT=1 and
// WIDTH=16/DIGIT=4 instances sharing clock and reset.
module tb_serial_addsub;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8))  bus8 ();
  serial_addsub_if #(.WIDTH(16)) bus16 ();

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin);
    bus8.a     = a;
    bus8.b     = b;
    bus8.sub   = sub;
    bus8.cin   = cin;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_done16(output int lat);
    lat = 0;
    while (bus16.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic result8(input string tag, input logic [7:0] es, input logic ecf,
                         input logic eof, input logic ezf);
    check({tag, ".s"},  bus8.s,  es);
    check({tag, ".cf"}, bus8.cf, ecf);
    check({tag, ".of"}, bus8.of, eof);
    check({tag, ".zf"}, bus8.zf, ezf);
  endtask

  initial begin
    int lat;
    bit busy_ok;
    int done_cnt;

    bus8.start  = 1'b0; bus8.sub  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0;
    bus16.start = 1'b0; bus16.sub = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst.busy", bus8.busy, 1'b0);
    check("rst.done", bus8.done, 1'b0);
    result8("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // 0x7F + 0x01: signed overflow, latency 8
    start8(8'h7F, 8'h01, 1'b0, 1'b0);
    check("s1.busy_edge0", bus8.busy, 1'b1);
    wait_done8(lat);
    check("s1.latency", lat, 8);
    result8("s1", SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b0);
    tick();
    check("s1.done_pulse", bus8.done, 1'b0);
    check("s1.busy_after", bus8.busy, 1'b0);

    // 0x05 - 0x07 with and without borrow-in
    start8(8'h05, 8'h07, 1'b1, 1'b0);
    wait_done8(lat);
    check("s2a.latency", lat, 8);
    result8("s2a", 8'hFE, 1'b0, 1'b0, 1'b0);
    start8(8'h05, 8'h07, 1'b1, 1'b1);
    wait_done8(lat);
    result8("s2b", 8'hFD, 1'b0, 1'b0, 1'b0);

    // 0xFF + 0x01 wraps to zero; 0x80 - 0x01 overflows negative to positive
    start8(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done8(lat);
    result8("s3a", 8'h00, 1'b1, 1'b0, 1'b1);
    start8(8'h80, 8'h01, 1'b1, 1'b0);
    wait_done8(lat);
    result8("s3b", SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1, 1'b0);
    tick();

    // Start pulse with new operands during RUN is ignored
    start8(8'h3C, 8'h0A, 1'b0, 1'b0);
    busy_ok  = 1'b1;
    done_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) begin
        bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.sub = 1'b1; bus8.cin = 1'b1;
        bus8.start = 1'b1;
      end
      tick();
      bus8.start = 1'b0;
      if (i < 8 && bus8.busy !== 1'b1) busy_ok = 1'b0;
      if (bus8.done === 1'b1) done_cnt++;
    end
    check("s4.busy_continuous", busy_ok, 1'b1);
    check("s4.done", bus8.done, 1'b1);
    result8("s4", 8'h46, 1'b0, 1'b0, 1'b0);
    tick();
    if (bus8.done === 1'b1) done_cnt++;
    check("s4.done_count", done_cnt, 1);
    check("s4.idle", bus8.busy, 1'b0);

    // Asynchronous reset in the middle of RUN
    start8(8'h11, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("s5.busy_before", bus8.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("s5.busy", bus8.busy, 1'b0);
    check("s5.done", bus8.done, 1'b0);
    result8("s5.rst", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("s5.idle_after_release", bus8.busy, 1'b0);
    start8(8'h50, 8'h30, 1'b1, 1'b0);
    wait_done8(lat);
    check("s5.latency", lat, 8);
    result8("s5", 8'h20, 1'b1, 1'b0, 1'b0);

    // WIDTH=16, DIGIT=4: latency 4, then back-to-back start in DONE
    bus16.a = 16'h1234; bus16.b = 16'h0FFF; bus16.sub = 1'b0; bus16.cin = 1'b1;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    check("s6.busy_edge0", bus16.busy, 1'b1);
    wait_done16(lat);
    check("s6.latency", lat, 4);
    check("s6.s",  bus16.s,  16'h2234);
    check("s6.cf", bus16.cf, 1'b0);
    check("s6.of", bus16.of, 1'b0);
    check("s6.zf", bus16.zf, 1'b0);
    bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.cin = 1'b0;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    check("s6b.busy_b2b", bus16.busy, 1'b1);
    check("s6b.done_low", bus16.done, 1'b0);
    check("s6b.s_held", bus16.s, 16'h2234);
    wait_done16(lat);
    check("s6b.latency", lat, 4);
    check("s6b.s",  bus16.s,  16'h0000);
    check("s6b.cf", bus16.cf, 1'b1);
    check("s6b.of", bus16.of, 1'b0);
    check("s6b.zf", bus16.zf, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle adder/subtractor that processes operands DIGIT bits per clock, LSB first, through a DIGIT-wide ripple-carry slice.
- Successor to the fixed 4-bit combinational ripple adder: adds width generalisation, subtract mode, a start/done handshake, and full carry/overflow/zero flags.
- Sits in the datapath lab as the shared arithmetic unit behind the ALU controller, trading latency for area.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when not busy.
- sub  input  1  0: s = a + b + cin; 1: s = a - b - cin (cin acts as borrow-in).
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in (add) / borrow-in (sub), captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results valid and stable from this cycle.
- s  output  WIDTH  result.
- cf  output  1  raw carry out of the MSB (sub: 1 = no borrow).
- of  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zf  output  1  s == 0 (after saturation, if enabled).

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1: latch a, b, sub, cin; set digit counter to 0; go to RUN.
- IDLE/DONE, start=0: DONE goes to IDLE; IDLE holds.
- RUN: each cycle, add digit k of A and B' (B' = sub ? ~b : b) with the running carry. The initial carry is sub ? ~cin : cin. Write the sum digit into the result shift register and increment the counter.
- RUN, after digit N-1: go to DONE and update s/cf/of/zf.
- RUN ignores start and ignores changes on a/b/sub/cin.
- of uses the carry into the MSB, i.e. the carry out of bit WIDTH-2 of the final slice. With DIGIT=1 this is the carry stored from the previous cycle.
- s, cf, of, zf hold their last values until the next operation completes; they do not change during RUN.
- Counter width: clog2(N), minimum 1 bit.

## Timing
- Reset (asynchronous, any state, including mid-RUN): state=IDLE, busy=0, done=0, s=0, cf=0, of=0, zf=0. The partial result is discarded.
- An accepted start at edge 0 sets busy=1 from edge 0.
- Digits are processed at edges 1..N.
- At edge N: busy=0, done=1 for exactly one cycle, flags and s updated.
- Latency from start edge to done: N cycles (WIDTH=8: DIGIT=1 gives 8, DIGIT=4 gives 2).
- Back-to-back: start=1 in the DONE cycle is accepted, so busy goes high again at the next edge. Sustained throughput is one result per N+1 cycles.
- start held high continuously is accepted once per IDLE/DONE visit, never during RUN.

## Configuration
- SERIAL_ADDSUB_SAT_EN defined: signed saturation.
  - When of=1, s clamps: 0111…1 if the captured a[WIDTH-1]=0, else 1000…0.
  - of and cf still report the unsaturated operation.
  - zf is evaluated on the clamped s.
- Not defined: s is the wrapped WIDTH-bit result and there is no saturation logic.

## Test plan
Scenarios 1–5 use WIDTH=8, DIGIT=1, macro off unless stated.
1. a=0x7F, b=0x01, sub=0, cin=0 -> done exactly 8 cycles after the start edge; s=0x80, cf=0, of=1, zf=0. With SERIAL_ADDSUB_SAT_EN: s=0x7F, of=1.
2. a=0x05, b=0x07, sub=1, cin=0 -> s=0xFE, cf=0 (borrow), of=0, zf=0. Same with cin=1 -> s=0xFD.
3. a=0xFF, b=0x01, sub=0, cin=0 -> s=0x00, cf=1, of=0, zf=1. a=0x80, b=0x01, sub=1 -> s=0x7F, of=1 (sat: s=0x80).
4. Pulse start at cycle 3 of RUN with different operands -> ignored; the result matches the first operands; busy is continuous and done pulses once.
5. Deassert rst_n at RUN cycle 4 -> all outputs 0 immediately, state IDLE. A new start after release completes normally with the correct result.
6. WIDTH=16, DIGIT=4, a=0x1234, b=0x0FFF, sub=0, cin=1 -> done 4 cycles after start, s=0x2234, cf=0, of=0. Back-to-back start in the DONE cycle is accepted.
